// File: rtl/icache_tag_ram_nway_pkg.sv
// Shared definitions for the instruction-cache tag store: default geometry,
// the stored {valid, tag} entry layout and the clear-sweep state encoding.
package icache_tag_ram_nway_pkg;

    localparam int DEF_WAYS  = 2;
    localparam int DEF_SET_W = 7;
    localparam int DEF_TAG_W = 20;

    typedef struct packed {
        logic                 valid;
        logic [DEF_TAG_W-1:0] tag;
    } tag_entry_t;

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_IDLE  = 1'b1
    } sweep_state_e;

    // Way-select fields keep at least one bit so a direct-mapped build still has a port.
    function automatic int way_idx_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/icache_tag_ram_nway_if.sv
// Bundle between the icache pipeline / refill controller (master) and the
// tag store (slave): two lookup ports, fill, CACOP invalidate and flush.
interface icache_tag_ram_nway_if
    import icache_tag_ram_nway_pkg::*;
#(
    parameter int WAYS  = DEF_WAYS,
    parameter int SET_W = DEF_SET_W,
    parameter int TAG_W = DEF_TAG_W
);
    localparam int WAY_W = way_idx_w(WAYS);
    localparam int ENT_W = TAG_W + 1;

    logic                  rd_en1;
    logic [SET_W-1:0]      rd_index1;
    logic [TAG_W-1:0]      rd_tag1;
    logic [WAYS*ENT_W-1:0] rd_tags1;
    logic [WAYS-1:0]       hit_way1;
    logic                  hit1;

    logic                  rd_en2;
    logic [SET_W-1:0]      rd_index2;
    logic [TAG_W-1:0]      rd_tag2;
    logic [WAYS*ENT_W-1:0] rd_tags2;
    logic [WAYS-1:0]       hit_way2;
    logic                  hit2;

    logic                  we;
    logic [WAY_W-1:0]      we_way;
    logic [SET_W-1:0]      we_index;
    logic [TAG_W-1:0]      we_tag;

    logic                  inv_en;
    logic                  inv_all_ways;
    logic [WAY_W-1:0]      inv_way;
    logic [SET_W-1:0]      inv_index;

    logic                  flush_all;
    logic                  ready;
    sweep_state_e          state_dbg;

    // we, inv_en and flush_all are single-cycle requests taken only on an edge
    // where ready=1; on an edge with ready=0 they are dropped, so a requester holds
    // its request until it sees ready=1. Lookups need no handshake: a result
    // appears one edge after rd_en and reads as zero whenever ready=0.
    modport master (
        output rd_en1, rd_index1, rd_tag1,
        output rd_en2, rd_index2, rd_tag2,
        output we, we_way, we_index, we_tag,
        output inv_en, inv_all_ways, inv_way, inv_index,
        output flush_all,
        input  rd_tags1, hit_way1, hit1,
        input  rd_tags2, hit_way2, hit2,
        input  ready, state_dbg
    );

    modport slave (
        input  rd_en1, rd_index1, rd_tag1,
        input  rd_en2, rd_index2, rd_tag2,
        input  we, we_way, we_index, we_tag,
        input  inv_en, inv_all_ways, inv_way, inv_index,
        input  flush_all,
        output rd_tags1, hit_way1, hit1,
        output rd_tags2, hit_way2, hit2,
        output ready, state_dbg
    );

endinterface

// File: rtl/icache_tag_ram_nway_bank.sv
// One way of the tag store: SETS x ENT_W RAM with one write port and two
// registered, read-first read ports whose output registers can be cleared.
module icache_tag_ram_nway_bank
    import icache_tag_ram_nway_pkg::*;
#(
    parameter int SET_W = DEF_SET_W,
    parameter int ENT_W = DEF_TAG_W + 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [SET_W-1:0] waddr,
    input  logic [ENT_W-1:0] wdata,
    input  logic             rclr,
    input  logic             re1,
    input  logic [SET_W-1:0] raddr1,
    output logic [ENT_W-1:0] rdata1,
    input  logic             re2,
    input  logic [SET_W-1:0] raddr2,
    output logic [ENT_W-1:0] rdata2
);
    localparam int SETS = 2 ** SET_W;

    (* ram_style = "block" *) logic [ENT_W-1:0] mem [SETS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads sample mem before this edge's write lands, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (rclr) begin
            rdata1 <= '0;
        end else if (re1) begin
            rdata1 <= mem[raddr1];
        end
    end

    always_ff @(posedge clk) begin
        if (rclr) begin
            rdata2 <= '0;
        end else if (re2) begin
            rdata2 <= mem[raddr2];
        end
    end

endmodule

// File: rtl/icache_tag_ram_nway.sv
// N-way set-associative icache tag store: per-way RAM banks, clear-sweep FSM,
// fill/invalidate write decode and per-way hit compare for two lookup ports.
module icache_tag_ram_nway
    import icache_tag_ram_nway_pkg::*;
#(
    parameter int WAYS  = DEF_WAYS,
    parameter int SET_W = DEF_SET_W,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    icache_tag_ram_nway_if.slave bus
);
    localparam int SETS  = 2 ** SET_W;
    localparam int ENT_W = TAG_W + 1;

    sweep_state_e     state_q, state_d;
    logic [SET_W-1:0] cnt_q, cnt_d;

    logic [WAYS-1:0]  bank_we;
    logic [SET_W-1:0] wr_addr;
    logic [ENT_W-1:0] wr_data;
    logic             rd_clr;

    logic [ENT_W-1:0] q1 [WAYS];
    logic [ENT_W-1:0] q2 [WAYS];
    logic [TAG_W-1:0] tag1_q, tag2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A fill outranks an invalidate; the sweep owns the write port outright.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_we = '0;
        wr_addr = bus.we_index;
        wr_data = '0;
        case (state_q)
            ST_SWEEP: begin
                bank_we = '1;
                wr_addr = cnt_q;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == SET_W'(SETS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.we) begin
                    bank_we = WAYS'(1) << bus.we_way;
                    wr_data = {1'b1, bus.we_tag};
                end else if (bus.inv_en) begin
                    wr_addr = bus.inv_index;
                    bank_we = bus.inv_all_ways ? '1 : (WAYS'(1) << bus.inv_way);
                end
                if (bus.flush_all) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_SWEEP;
                cnt_d   = '0;
            end
        endcase
    end

    assign rd_clr = !rst_n || (state_q == ST_SWEEP);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_tag_ram_nway_bank #(
            .SET_W (SET_W),
            .ENT_W (ENT_W)
        ) u_bank (
            .clk    (clk),
            .we     (bank_we[w]),
            .waddr  (wr_addr),
            .wdata  (wr_data),
            .rclr   (rd_clr),
            .re1    (bus.rd_en1),
            .raddr1 (bus.rd_index1),
            .rdata1 (q1[w]),
            .re2    (bus.rd_en2),
            .raddr2 (bus.rd_index2),
            .rdata2 (q2[w])
        );
    end

    always_ff @(posedge clk) begin
        if (rd_clr) begin
            tag1_q <= '0;
            tag2_q <= '0;
        end else begin
            if (bus.rd_en1) tag1_q <= bus.rd_tag1;
            if (bus.rd_en2) tag2_q <= bus.rd_tag2;
        end
    end

    // Results are masked outside IDLE so a lookup captured on the flush edge cannot leak a hit.
    always_comb begin
        bus.rd_tags1 = '0;
        bus.rd_tags2 = '0;
        bus.hit_way1 = '0;
        bus.hit_way2 = '0;
        if (state_q == ST_IDLE) begin
            for (int w = 0; w < WAYS; w++) begin
                bus.rd_tags1[w*ENT_W +: ENT_W] = q1[w];
                bus.rd_tags2[w*ENT_W +: ENT_W] = q2[w];
                bus.hit_way1[w] = q1[w][ENT_W-1] && (q1[w][TAG_W-1:0] == tag1_q);
                bus.hit_way2[w] = q2[w][ENT_W-1] && (q2[w][TAG_W-1:0] == tag2_q);
            end
        end
    end

    assign bus.hit1      = |bus.hit_way1;
    assign bus.hit2      = |bus.hit_way2;
    assign bus.ready     = (state_q == ST_IDLE);
    assign bus.state_dbg = state_q;

endmodule
